data_mem_be: RTL and testbench

//  Parametrised pipeline data memory with byte/halfword/word access, sign/zero

---
 rtl/data_mem_be.sv | 158 +++++++++++++++
 tb/tb_data_mem_be.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_be.sv
// MEM-stage data memory: byte/half/word stores with lane enables, sign/zero-extended
// registered loads, fault flagging and an optional post-reset zero-fill sweep.
module data_mem_be #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          INIT_CLEAR  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned BYTES = DEPTH_WORDS * 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [0:0] {S_CLEAR, S_READY} state_t;
  localparam state_t RESET_STATE = INIT_CLEAR ? S_CLEAR : S_READY;

  logic [31:0] mem [DEPTH_WORDS];

  state_t           state, state_next;
  logic [IDX_W-1:0] cnt, cnt_next;
  logic [31:0]      rdata_next;
  logic             rvalid_next, err_next, busy_next;

  logic [IDX_W-1:0] idx_c, mem_idx_c;
  logic             range_c, misalign_c, fault_c, mem_we_c;
  logic [3:0]       be_c, mem_be_c;
  logic [31:0]      wd_c, mem_wd_c, word_c, load_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;

  // Request decode and fault detection
  assign idx_c      = addr[IDX_W+1:2];
  assign range_c    = {1'b0, addr} >= (ADDR_W+1)'(BYTES);
  assign misalign_c = ((size == SZ_HALF) && addr[0]) ||
                      ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign fault_c    = (rd && wr) || (size == SZ_ILL) || range_c || misalign_c;
  assign word_c     = mem[idx_c];

  // Load lane selection and extension
  always_comb begin
    byte_c = word_c[7:0];
    case (addr[1:0])
      2'b01:   byte_c = word_c[15:8];
      2'b10:   byte_c = word_c[23:16];
      2'b11:   byte_c = word_c[31:24];
      default: byte_c = word_c[7:0];
    endcase
    half_c = addr[1] ? word_c[31:16] : word_c[15:0];
    case (size)
      SZ_BYTE: load_c = load_unsigned ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
      SZ_HALF: load_c = load_unsigned ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
      default: load_c = word_c;
    endcase
  end

  // Store lane enables with data replicated across lanes
  always_comb begin
    be_c = 4'b0000;
    wd_c = wdata;
    case (size)
      SZ_BYTE: begin
        be_c = 4'b0001 << addr[1:0];
        wd_c = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be_c = addr[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{wdata[15:0]}};
      end
      SZ_WORD: be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    busy_next   = busy;
    rdata_next  = rdata;
    rvalid_next = 1'b0;
    err_next    = 1'b0;
    mem_we_c    = 1'b0;
    mem_idx_c   = idx_c;
    mem_be_c    = be_c;
    mem_wd_c    = wd_c;

    if (state == S_CLEAR) begin
      mem_we_c  = 1'b1;
      mem_idx_c = cnt;
      mem_be_c  = 4'b1111;
      mem_wd_c  = 32'd0;
      busy_next = 1'b1;
      cnt_next  = cnt + 1'b1;
      if (cnt == IDX_W'(DEPTH_WORDS - 1)) begin
        state_next = S_READY;
        busy_next  = 1'b0;
        cnt_next   = '0;
      end
    end else begin
      busy_next = 1'b0;
      if (rd || wr) begin
        if (fault_c) begin
          err_next   = 1'b1;
          rdata_next = 32'd0;
        end else if (wr) begin
          mem_we_c = 1'b1;
        end else begin
          rdata_next  = load_c;
          rvalid_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RESET_STATE;
      cnt    <= '0;
      busy   <= INIT_CLEAR;
      rdata  <= 32'd0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy   <= busy_next;
      rdata  <= rdata_next;
      rvalid <= rvalid_next;
      err    <= err_next;
    end
  end

  // Storage array has no reset; the sweep provides the zero state
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_c[b]) mem[mem_idx_c][8*b +: 8] <= mem_wd_c[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_be.sv
// Directed bench for data_mem_be: sweep timing, lane stores, extended loads,
// faults, read-after-write and reset during the sweep.
module tb_data_mem_be;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 32;
  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SX = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd, wr, load_unsigned;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid, err, busy;

  int checks = 0;
  int errors = 0;
  int n;
  logic stray;

  data_mem_be #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .size(size),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request cycle: drive on negedge, return just after the capturing posedge
  task automatic req(input logic r, input logic w, input logic [1:0] sz, input logic lu,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rd = r; wr = w; size = sz; load_unsigned = lu; addr = a; wdata = d;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic lu,
                    input logic [31:0] a, input logic [31:0] exp);
    req(1'b1, 1'b0, sz, lu, a, 32'd0);
    check({tag, ".rdata"}, rdata, exp);
    check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] d);
    req(1'b0, 1'b1, sz, 1'b0, a, d);
    check({tag, ".rvalid"}, 32'(rvalid), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  task automatic flt(input string tag, input logic r, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d);
    req(r, w, sz, 1'b0, a, d);
    check({tag, ".err"}, 32'(err), 32'd1);
    check({tag, ".rvalid"}, 32'(rvalid), 32'd0);
    check({tag, ".rdata"}, rdata, 32'd0);
  endtask

  // Counts posedges until busy drops (bounded), noting any rvalid/err seen meanwhile
  task automatic wait_sweep(output int cycles, output logic seen);
    cycles = 0;
    seen = 1'b0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      seen = seen | rvalid | err;
    end while (busy && cycles < 100);
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; size = SW; load_unsigned = 1'b0;
    addr = '0; wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd1);
    check("rst.rvalid", 32'(rvalid), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.rdata", rdata, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    wait_sweep(n, stray);
    check("sweep.cycles", 32'(n), 32'd16);
    check("sweep.quiet", 32'(stray), 32'd0);
    ld("t1.lw3c", SW, 1'b0, 32'h3C, 32'h0000_0000);

    st("t2.sw8", SW, 32'h8, 32'hDEAD_BEEF);
    st("t2.sb9", SB, 32'h9, 32'h0000_0011);
    ld("t2.lb9", SB, 1'b0, 32'h9, 32'h0000_0011);
    ld("t2.lw8", SW, 1'b0, 32'h8, 32'hDEAD_11EF);

    st("t3.sh6", SH, 32'h6, 32'h0000_8001);
    ld("t3.lh6", SH, 1'b0, 32'h6, 32'hFFFF_8001);
    ld("t3.lhu6", SH, 1'b1, 32'h6, 32'h0000_8001);
    ld("t3.lb7", SB, 1'b0, 32'h7, 32'hFFFF_FF80);
    ld("t3.lbu7", SB, 1'b1, 32'h7, 32'h0000_0080);

    // Idle cycle: rdata holds, flags drop
    @(negedge clk);
    @(posedge clk);
    #1;
    check("idle.rdata", rdata, 32'h0000_0080);
    check("idle.rvalid", 32'(rvalid), 32'd0);

    flt("t4.lw2", 1'b1, 1'b0, SW, 32'h2, 32'd0);
    flt("t4.sh5", 1'b0, 1'b1, SH, 32'h5, 32'h0000_FFFF);
    flt("t4.size11", 1'b0, 1'b1, SX, 32'h8, 32'hFFFF_FFFF);
    flt("t4.lw40", 1'b1, 1'b0, SW, 32'h40, 32'd0);
    flt("t4.sw40", 1'b0, 1'b1, SW, 32'h40, 32'hFFFF_FFFF);
    flt("t4.rdwr", 1'b1, 1'b1, SW, 32'h8, 32'h1234_5678);
    ld("t4.lw4", SW, 1'b0, 32'h4, 32'h8001_0000);
    ld("t4.lw8", SW, 1'b0, 32'h8, 32'hDEAD_11EF);
    ld("t4.lw0", SW, 1'b0, 32'h0, 32'h0000_0000);

    st("t5.sw10", SW, 32'h10, 32'hA5A5_A5A5);
    ld("t5.lw10", SW, 1'b0, 32'h10, 32'hA5A5_A5A5);

    // Async reset takes effect without a clock edge
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6.rst.rdata", rdata, 32'd0);
    check("t6.rst.rvalid", 32'(rvalid), 32'd0);
    check("t6.rst.busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    wr = 1'b1; size = SW; addr = 32'h0; wdata = 32'hFFFF_FFFF;
    repeat (5) @(posedge clk);
    #1;
    check("t6.mid.busy", 32'(busy), 32'd1);
    check("t6.mid.rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6.rst2.busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    wait_sweep(n, stray);
    wr = 1'b0;
    check("t6.sweep.cycles", 32'(n), 32'd16);
    check("t6.sweep.quiet", 32'(stray), 32'd0);
    ld("t6.lw0", SW, 1'b0, 32'h0, 32'h0000_0000);
    ld("t6.lw10", SW, 1'b0, 32'h10, 32'h0000_0000);
    ld("t6.lw8", SW, 1'b0, 32'h8, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
